// File: rtl/alu_shift_stage.sv
// alu_shift_stage: two-stage valid/ready RV32 shift/rotate unit; Zbb rotates enabled by ALU_SHIFT_ROTATE_EN
module alu_shift_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  logic             s1_v, s2_v, s2_load, legal, s2_ill;
  logic             is_sll, is_srl, is_sra, is_rol, is_ror;
  logic [31:0]      s1_rs1, sh_res, sra_res, s2_res;
  logic [4:0]       s1_s, shamt;
  logic [2:0]       s1_f3;
  logic [6:0]       s1_f7;
  logic [1:0]       oper;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic             unused_rs2;
  assign unused_rs2  = &{1'b0, in_rs2[31:5]};
  assign s2_load     = s1_v && (!s2_v || out_ready);
  assign in_ready    = !rst && (!s1_v || s2_load);
  assign out_valid   = s2_v;
  assign out_result  = s2_res;
  assign out_tag     = s2_tag;
  assign out_illegal = s2_ill;
  // decode S1 fields into shifter operation and shift amount
  always_comb begin
    is_sll = s1_f3 == 3'b001 && s1_f7 == 7'b0000000;
    is_srl = s1_f3 == 3'b101 && s1_f7 == 7'b0000000;
    is_sra = s1_f3 == 3'b101 && s1_f7 == 7'b0100000;
`ifdef ALU_SHIFT_ROTATE_EN
    is_rol = s1_f3 == 3'b001 && s1_f7 == 7'b0110000;
    is_ror = s1_f3 == 3'b101 && s1_f7 == 7'b0110000;
    shamt  = is_ror ? ~s1_s + 5'd1 : s1_s;
`else
    is_rol = 1'b0;
    is_ror = 1'b0;
    shamt  = s1_s;
`endif
    legal = is_sll || is_srl || is_sra || is_rol || is_ror;
    oper  = is_sll ? 2'b01 : is_sra ? 2'b10 : is_srl ? 2'b11 : 2'b00;
  end
  // combinational barrel shifter: 00 rotate-left, 01 sll, 10 sra, 11 srl
  always_comb begin
    sra_res = $signed(s1_rs1) >>> shamt;
    sh_res  = oper == 2'b00 ? (s1_rs1 << shamt) | (s1_rs1 >> (6'd32 - {1'b0, shamt})) :
              oper == 2'b01 ? s1_rs1 << shamt :
              oper == 2'b10 ? sra_res : s1_rs1 >> shamt;
  end
  // stage 1 capture; empties when its operation moves to stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_rs1 <= '0;
      s1_s   <= '0;
      s1_f3  <= '0;
      s1_f7  <= '0;
      s1_tag <= '0;
    end else if (in_valid && in_ready) begin
      s1_v   <= 1'b1;
      s1_rs1 <= in_rs1;
      s1_s   <= in_rs2[4:0];
      s1_f3  <= in_funct3;
      s1_f7  <= in_funct7;
      s1_tag <= in_tag;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end
  // stage 2 result register; illegal operations yield zero with the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_res <= '0;
      s2_tag <= '0;
      s2_ill <= 1'b0;
    end else if (s2_load) begin
      s2_v   <= 1'b1;
      s2_res <= legal ? sh_res : 32'h0;
      s2_tag <= s1_tag;
      s2_ill <= !legal;
    end else if (out_ready) begin
      s2_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_shift_stage.sv
// tb_alu_shift_stage: scoreboard bench for alu_shift_stage (honours ALU_SHIFT_ROTATE_EN)
module tb_alu_shift_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_illegal;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, out_result;
  logic [4:0]  in_tag = '0, out_tag;

  typedef struct packed {logic [2:0] f3; logic [6:0] f7; logic [31:0] rs1; logic [31:0] rs2; logic [4:0] tag;} op_t;
  typedef struct packed {logic ill; logic [31:0] res; logic [4:0] tag;} exp_t;

  op_t  pend[$];
  exp_t sb[$];
  int   n_chk = 0, n_bad = 0, n_out = 0, n_noready = 0, last_cycles = 0;
  logic stall = 1'b0, prev_ill;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;

  alu_shift_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [31:0] r;
    logic ill;
    r = o.rs1;
    ill = 1'b0;
    for (int i = 0; i < int'(o.rs2[4:0]); i++) begin
      if (o.f3 == 3'd1 && o.f7 == 7'h00) r = {r[30:0], 1'b0};
      else if (o.f3 == 3'd5 && o.f7 == 7'h00) r = {1'b0, r[31:1]};
      else if (o.f3 == 3'd5 && o.f7 == 7'h20) r = {r[31], r[31:1]};
`ifdef ALU_SHIFT_ROTATE_EN
      else if (o.f3 == 3'd1 && o.f7 == 7'h30) r = {r[30:0], r[31]};
      else if (o.f3 == 3'd5 && o.f7 == 7'h30) r = {r[0], r[31:1]};
`endif
    end
    ill = !((o.f3 == 3'd1 && o.f7 == 7'h00) || (o.f3 == 3'd5 && (o.f7 == 7'h00 || o.f7 == 7'h20))
`ifdef ALU_SHIFT_ROTATE_EN
            || ((o.f3 == 3'd1 || o.f3 == 3'd5) && o.f7 == 7'h30)
`endif
            );
    e.ill = ill;
    e.res = ill ? 32'h0 : r;
    e.tag = o.tag;
    return e;
  endfunction

  task automatic cycle(input logic ordy);
    op_t o;
    exp_t e;
    o = pend.size() != 0 ? pend[0] : '0;
    in_valid = pend.size() != 0;
    in_funct3 = o.f3;
    in_funct7 = o.f7;
    in_rs1 = o.rs1;
    in_rs2 = o.rs2;
    in_tag = o.tag;
    out_ready = ordy;
    #1;
    if (!rst) begin
      check("in_ready", in_ready, (sb.size() < 2) || ordy);
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_res", out_result, prev_res);
        check("hold_tag", out_tag, prev_tag);
        check("hold_ill", out_illegal, prev_ill);
      end
      stall = out_valid && !out_ready;
      prev_res = out_result;
      prev_tag = out_tag;
      prev_ill = out_illegal;
      if (!in_ready) n_noready++;
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("tag", out_tag, e.tag);
          check("illegal", out_illegal, e.ill);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(o));
        void'(pend.pop_front());
      end
    end else stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input int budget, input int pat);
    int c;
    c = 0;
    while ((pend.size() != 0 || sb.size() != 0) && c < budget) begin
      cycle(pat == 0 ? 1'b1 : pat == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1)));
      c++;
    end
    check("drained", pend.size() + sb.size(), 0);
    last_cycles = c;
  endtask

  function automatic op_t mk(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [4:0] tag);
    return '{f3: f3, f7: f7, rs1: rs1, rs2: rs2, tag: tag};
  endfunction

  initial begin
    int n0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_ill", out_illegal, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    // SLL with latency check
    pend.push_back(mk(3'b001, 7'h00, 32'h0000_0001, 32'd31, 5'd7));
    cycle(1'b1);
    check("sll_accepted", pend.size(), 0);
    check("lat_n1", out_valid, 0);
    cycle(1'b1);
    check("lat_n2", out_valid, 1);
    check("sll_res", out_result, 32'h8000_0000);
    run(10, 0);
    // directed set at full rate: 8 ops must take exactly 10 cycles
    pend.push_back(mk(3'b101, 7'h20, 32'hF000_0000, 32'd4, 5'd1));
    pend.push_back(mk(3'b101, 7'h00, 32'hF000_0000, 32'd4, 5'd2));
    pend.push_back(mk(3'b101, 7'h30, 32'h0000_0001, 32'd1, 5'd3));
    pend.push_back(mk(3'b101, 7'h30, 32'h0000_0001, 32'd0, 5'd4));
    pend.push_back(mk(3'b001, 7'h30, 32'h8000_0001, 32'd4, 5'd5));
    pend.push_back(mk(3'b000, 7'h00, 32'h1234_5678, 32'd3, 5'd6));
    pend.push_back(mk(3'b101, 7'h20, 32'h8765_4321, 32'hFFFF_FFE0, 5'd8));
    pend.push_back(mk(3'b001, 7'h01, 32'hDEAD_BEEF, 32'd2, 5'd9));
    n0 = n_noready;
    run(40, 0);
    check("full_rate_cycles", last_cycles, 10);
    check("full_rate_no_stall", n_noready - n0, 0);
    // back-pressure stream, tags 1..6
    for (int i = 1; i <= 6; i++) pend.push_back(mk(3'b101, 7'h20, 32'h8000_0000 >> i, i, 5'(i)));
    n0 = n_out;
    n_noready = 0;
    run(100, 1);
    check("bp_count", n_out - n0, 6);
    check("bp_in_ready_dropped", n_noready > 0, 1);
    // random mix with random back-pressure
    for (int i = 0; i < 40; i++) begin
      logic [6:0] f7s [4];
      f7s = '{7'h00, 7'h20, 7'h30, 7'($urandom)};
      pend.push_back(mk(i % 5 == 4 ? 3'($urandom) : (i % 2 ? 3'b101 : 3'b001),
                        f7s[$urandom_range(0, 3)], $urandom, $urandom, 5'(i)));
    end
    run(1000, 2);
    // reset with two operations in flight
    pend.push_back(mk(3'b001, 7'h00, 32'h1, 32'd1, 5'd20));
    pend.push_back(mk(3'b001, 7'h00, 32'h2, 32'd1, 5'd21));
    cycle(1'b0);
    cycle(1'b0);
    check("inflight_two", sb.size(), 2);
    check("inflight_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    sb.delete();
    n0 = n_out;
    for (int i = 0; i < 5; i++) cycle(1'b1);
    check("post_rst_no_output", n_out - n0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
